// File: rtl/arb_mux_n_pkg.sv
// rtl/arb_mux_n_pkg.sv - mode constants and elaboration helpers for arb_mux_n
`ifndef ARB_MUX_DEFS
`define ARB_MUX_DEFS
`define ARB_MODE_SEL 0
`define ARB_MODE_RR  1
`endif

package arb_mux_n_pkg;

    localparam int MODE_SEL = `ARB_MODE_SEL;
    localparam int MODE_RR  = `ARB_MODE_RR;

    // Smallest r with 2**r >= n; used to validate the select width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// rtl/rr_pick_n.sv - combinational rotate-priority picker starting after the last grant
module rr_pick_n #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                gnt_any
);

    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        // Offsets 1..CHANNELS put the previous winner last in line.
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(last) + i) % CHANNELS;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - N-channel registered mux with select or round-robin grant
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic             can_load;
    logic             gnt_any;
    logic             xfer;
    logic [SEL_W-1:0] gnt;
    logic [WIDTH-1:0] gnt_data;

    generate
        if (CHANNELS < 2 || SEL_W < clog2(CHANNELS)) begin : g_param_check
            $error("arb_mux_n: CHANNELS must be >= 2 and SEL_W >= clog2(CHANNELS)");
        end
    endgenerate

    assign can_load = !out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] last;

            rr_pick_n #(
                .CHANNELS (CHANNELS),
                .SEL_W    (SEL_W)
            ) u_pick (
                .req     (in_valid),
                .last    (last),
                .gnt_idx (gnt),
                .gnt_any (gnt_any)
            );

            // Pointer only advances on a real accept so a stalled winner keeps its turn.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    last <= SEL_W'(CHANNELS - 1);
                end else if (xfer) begin
                    last <= gnt;
                end
            end
        end else begin : g_sel
            assign gnt     = sel;
            assign gnt_any = (int'(sel) < CHANNELS);
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt == SEL_W'(k)) begin
                in_ready[k] = rst_n && gnt_any && can_load;
                gnt_data    = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    // A load in the same cycle as a drain replaces the beat without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_chan  <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - self-checking bench for arb_mux_n in select and round-robin modes
module tb_arb_mux_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  sel0, sel1, sel3;
    logic [19:0] data0, data1;
    logic [14:0] data3;
    logic [3:0]  vld0, vld1, rdy0, rdy1;
    logic [2:0]  vld3, rdy3;
    logic [4:0]  od0, od1, od3;
    logic [1:0]  oc0, oc1, oc3;
    logic        ov0, ov1, ov3, ordy0, ordy1, ordy3;

    arb_mux_n #(.WIDTH(5), .CHANNELS(4), .SEL_W(2), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .in_data(data0), .in_valid(vld0),
        .in_ready(rdy0), .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(ordy0));

    arb_mux_n #(.WIDTH(5), .CHANNELS(4), .SEL_W(2), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel1), .in_data(data1), .in_valid(vld1),
        .in_ready(rdy1), .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(ordy1));

    arb_mux_n #(.WIDTH(5), .CHANNELS(3), .SEL_W(2), .MODE(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel(sel3), .in_data(data3), .in_valid(vld3),
        .in_ready(rdy3), .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(ordy3));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [4:0] exp_od;
        logic [1:0] exp_oc;
    } vec_t;

    vec_t tbl [8];

    // Reference state: one output slot per DUT plus the round-robin pointer.
    logic       m0_ov, m1_ov;
    logic [4:0] m0_od, m1_od;
    int         m0_oc, m1_oc, m1_last;

    function automatic int pick(input int mode, input int ch, input int s,
                                input logic [3:0] vld, input int last);
        if (mode == 0) return (s < ch) ? s : -1;
        for (int i = 1; i <= ch; i++) begin
            int k;
            k = (last + i) % ch;
            if (vld[k]) return k;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m0_ov = 1'b0; m0_od = '0; m0_oc = 0;
        m1_ov = 1'b0; m1_od = '0; m1_oc = 0; m1_last = 3;
    endtask

    task automatic rand_cycle(input int n);
        int g0, g1;
        logic [3:0] r0, r1;
        sel0 = 2'($urandom_range(0, 3)); vld0 = 4'($urandom); data0 = 20'($urandom);
        ordy0 = ($urandom_range(0, 3) != 0);
        vld1 = 4'($urandom); data1 = 20'($urandom); sel1 = 2'($urandom);
        ordy1 = ($urandom_range(0, 3) != 0);
        #1;
        g0 = pick(0, 4, int'(sel0), vld0, 0);
        g1 = pick(1, 4, 0, vld1, m1_last);
        r0 = (g0 >= 0 && (!m0_ov || ordy0)) ? 4'(1 << g0) : 4'b0;
        r1 = (g1 >= 0 && (!m1_ov || ordy1)) ? 4'(1 << g1) : 4'b0;
        check($sformatf("rnd%0d_sel_in_ready", n), rdy0, r0);
        check($sformatf("rnd%0d_rr_in_ready", n), rdy1, r1);
        if (r0 != 0 && vld0[g0]) begin
            m0_ov = 1'b1; m0_od = data0[g0*5 +: 5]; m0_oc = g0;
        end else if (ordy0) begin
            m0_ov = 1'b0;
        end
        if (r1 != 0 && vld1[g1]) begin
            m1_ov = 1'b1; m1_od = data1[g1*5 +: 5]; m1_oc = g1; m1_last = g1;
        end else if (ordy1) begin
            m1_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d_sel_out", n), {ov0, od0, oc0}, {m0_ov, m0_od, 2'(m0_oc)});
        check($sformatf("rnd%0d_rr_out", n), {ov1, od1, oc1}, {m1_ov, m1_od, 2'(m1_oc)});
        @(negedge clk);
    endtask

    int exp_rr [6] = '{0, 1, 2, 3, 0, 1};
    int exp_wr [4] = '{3, 0, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sel0 = 2'd2; vld0 = 4'hF; ordy0 = 1'b1; data0 = {5'd4, 5'd3, 5'd2, 5'd1};
        sel1 = 2'd0; vld1 = 4'h0; ordy1 = 1'b1; data1 = {5'd4, 5'd3, 5'd2, 5'd1};
        sel3 = 2'd0; vld3 = 3'h0; ordy3 = 1'b1; data3 = {5'd9, 5'd8, 5'd7};

        tbl[0] = '{2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 5'd3, 2'd2};
        tbl[1] = '{2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 5'd3, 2'd2};
        tbl[2] = '{2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 5'd3, 2'd2};
        tbl[3] = '{2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 5'd3, 2'd2};
        tbl[4] = '{2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 5'd1, 2'd0};
        tbl[5] = '{2'd3, 4'h7, 1'b1, 4'b1000, 1'b0, 5'd1, 2'd0};
        tbl[6] = '{2'd3, 4'hF, 1'b0, 4'b1000, 1'b1, 5'd4, 2'd3};
        tbl[7] = '{2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 5'd2, 2'd1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_sel_out", {ov0, od0, oc0}, 0);
        check("reset_sel_in_ready", rdy0, 0);
        check("reset_rr_out", {ov1, od1, oc1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            sel0 = tbl[i].sel; vld0 = tbl[i].vld; ordy0 = tbl[i].ordy;
            #1;
            check($sformatf("tbl%0d_in_ready", i), rdy0, tbl[i].exp_rdy);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_out_valid", i), ov0, tbl[i].exp_ov);
            check($sformatf("tbl%0d_out_data", i), od0, tbl[i].exp_od);
            check($sformatf("tbl%0d_out_chan", i), oc0, tbl[i].exp_oc);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stall.
        sel0 = 2'd1; vld0 = 4'hF; ordy0 = 1'b0;
        @(posedge clk);
        #1;
        check("stall_before_reset_valid", ov0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", {ov0, od0, oc0}, 0);
        check("async_reset_in_ready", rdy0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness with back-to-back drain and load.
        vld1 = 4'hF; ordy1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_chan", i), oc1, exp_rr[i]);
            check($sformatf("rr%0d_valid", i), ov1, 1);
            check($sformatf("rr%0d_data", i), od1, exp_rr[i] + 1);
        end

        // Wrap and skip: channels 0 and 3 only.
        do_reset();
        vld1 = 4'b1001;
        @(posedge clk);
        #1;
        check("wrap_first_chan", oc1, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d_chan", i), oc1, exp_wr[i]);
            check($sformatf("wrap%0d_valid", i), ov1, 1);
        end

        // Out-of-range select on the 3-channel instance.
        @(negedge clk);
        sel3 = 2'd3; vld3 = 3'h7; ordy3 = 1'b1;
        #1;
        check("oor_in_ready", rdy3, 0);
        @(posedge clk);
        #1;
        check("oor_no_load", ov3, 0);
        @(negedge clk);
        sel3 = 2'd2;
        #1;
        check("ch3_sel2_in_ready", rdy3, 3'b100);
        @(posedge clk);
        #1;
        check("ch3_sel2_out", {ov3, od3, oc3}, {1'b1, 5'd9, 2'd2});

        do_reset();
        for (int n = 0; n < 400; n++) rand_cycle(n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
